serial_subtractor: RTL

//  Bit-serial subtractor: computes D = A - B (mod 2^WIDTH) on words streamed LSB-first, one bit of A and one of B per cycle.

---
 rtl/serial_subtractor.sv | 75 +++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial D = A - B (mod 2^WIDTH), words streamed LSB-first, one bit of a/b per cycle.
// Ports: clk, rst (sync, active-high); in_valid/in_first/a/b in; diff/diff_valid per bit,
// word/underflow/word_done at word end, frame_err pulse on framing violation. All outputs registered.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int CW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_first,
  input  logic             a,
  input  logic             b,
  output logic             diff,
  output logic             diff_valid,
  output logic             word_done,
  output logic [WIDTH-1:0] word,
  output logic             underflow,
  output logic             frame_err
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic borrow, bin, d, bout, accept, last;
  logic [WIDTH-1:0] sh;
  always_comb begin
    accept = in_valid & (in_first | (state == BUSY));
    bin = in_first ? 1'b0 : borrow;
    d = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
    last = (state == BUSY) & ~in_first & (cnt == CW'(WIDTH - 1));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      borrow <= 1'b0;
      sh <= '0;
      diff <= 1'b0;
      diff_valid <= 1'b0;
      word_done <= 1'b0;
      word <= '0;
      underflow <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      word_done <= 1'b0;
      frame_err <= 1'b0;
      diff_valid <= accept;
      if (accept) diff <= d;
      if (in_valid && in_first) begin
        // in_first while BUSY aborts the partial word and restarts on this bit
        frame_err <= (state == BUSY);
        state <= BUSY;
        cnt <= CW'(1);
        borrow <= bout;
        sh <= WIDTH'(d);
      end else if (in_valid && state == BUSY) begin
        sh[cnt] <= d;
        if (last) begin
          state <= IDLE;
          cnt <= '0;
          borrow <= 1'b0;
          word <= {d, sh[WIDTH-2:0]};
          underflow <= bout;
          word_done <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
          borrow <= bout;
        end
      end else if (in_valid) begin
        frame_err <= 1'b1;
      end
    end
  end
endmodule
